cnt4_ctrl: RTL and testbench

CNT4_CTRL -- requirements
Module: cnt4_ctrl

---
 rtl/cnt4_ctrl.sv | 89 ++++++++
 tb/tb_cnt4_ctrl.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/cnt4_ctrl.sv
// 4-bit accumulating counter that drives an external combinational adder and
// folds its sum/carry back into count, with wrap/saturate modes and sticky overflow.
module cnt4_ctrl #(
  parameter bit SAT = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       load,
  input  logic [3:0] load_val,
  input  logic [3:0] step,
  input  logic       clr_ovf,
  output logic [3:0] add_a,
  output logic [3:0] add_b,
  input  logic [3:0] add_s,
  input  logic       add_c,
  output logic [3:0] count,
  output logic       tc,
  output logic       ovf,
  output logic [1:0] state
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    SATD = 2'b10
  } state_t;

  state_t     state_q, state_d;
  logic [3:0] count_q, count_d;
  logic       tc_q, tc_d;
  logic       ovf_q, ovf_d;
  logic       ovf_set;

  // The adder sees a zero operand while idle so its result never matters then.
  assign add_a = count_q;
  assign add_b = en ? step : 4'h0;

  always_comb begin
    count_d = count_q;
    tc_d    = 1'b0;
    ovf_d   = ovf_q;
    state_d = state_q;
    ovf_set = 1'b0;

    if (load) begin
      count_d = load_val;
      state_d = RUN;
    end else if (en) begin
      if (state_q == IDLE) state_d = RUN;
      if (add_c) begin
        tc_d    = 1'b1;
        ovf_set = 1'b1;
        if (SAT) begin
          count_d = 4'hF;
          state_d = SATD;
        end else begin
          count_d = add_s;
        end
      end else begin
        // Without a carry in SATD the step must be zero, so pin at full scale.
        count_d = (state_q == SATD) ? 4'hF : add_s;
      end
    end

    if (ovf_set) ovf_d = 1'b1;
    else if (clr_ovf) ovf_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= 4'h0;
      tc_q    <= 1'b0;
      ovf_q   <= 1'b0;
      state_q <= IDLE;
    end else begin
      count_q <= count_d;
      tc_q    <= tc_d;
      ovf_q   <= ovf_d;
      state_q <= state_d;
    end
  end

  assign count = count_q;
  assign tc    = tc_q;
  assign ovf   = ovf_q;
  assign state = state_q;

endmodule

// File: tb/tb_cnt4_ctrl.sv
// Directed and randomized checks of cnt4_ctrl in wrap (u0) and saturate (u1)
// modes, each closed around its own behavioral 4-bit adder.
module tb_cnt4_ctrl;

  logic       clk = 1'b0;
  logic       rst, en, load, clr_ovf;
  logic [3:0] load_val, step;

  logic [3:0] add_a [2];
  logic [3:0] add_b [2];
  logic [3:0] add_s [2];
  logic       add_c [2];
  logic [3:0] count [2];
  logic       tc    [2];
  logic       ovf   [2];
  logic [1:0] state [2];

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  assign {add_c[0], add_s[0]} = {1'b0, add_a[0]} + {1'b0, add_b[0]};
  assign {add_c[1], add_s[1]} = {1'b0, add_a[1]} + {1'b0, add_b[1]};

  cnt4_ctrl #(.SAT(1'b0)) u0 (
    .clk(clk), .rst(rst), .en(en), .load(load), .load_val(load_val),
    .step(step), .clr_ovf(clr_ovf), .add_a(add_a[0]), .add_b(add_b[0]),
    .add_s(add_s[0]), .add_c(add_c[0]), .count(count[0]), .tc(tc[0]),
    .ovf(ovf[0]), .state(state[0])
  );

  cnt4_ctrl #(.SAT(1'b1)) u1 (
    .clk(clk), .rst(rst), .en(en), .load(load), .load_val(load_val),
    .step(step), .clr_ovf(clr_ovf), .add_a(add_a[1]), .add_b(add_b[1]),
    .add_s(add_s[1]), .add_c(add_c[1]), .count(count[1]), .tc(tc[1]),
    .ovf(ovf[1]), .state(state[1])
  );

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Packed view {state, ovf, tc, count}
  function automatic logic [7:0] pk(input int i);
    return {state[i], ovf[i], tc[i], count[i]};
  endfunction

  function automatic logic [7:0] mk(input logic [1:0] st, input logic o, input logic t,
                                    input logic [3:0] c);
    return {st, o, t, c};
  endfunction

  // Reference next-state model on the packed view.
  function automatic logic [7:0] model_next(input bit sat, input logic [7:0] cur);
    logic [1:0] st;
    logic       o, t, set;
    logic [3:0] c;
    logic [4:0] sum;
    st = cur[7:6]; o = cur[5]; c = cur[3:0]; t = 1'b0; set = 1'b0;
    if (rst) return 8'h00;
    sum = {1'b0, c} + {1'b0, (en ? step : 4'h0)};
    if (load) begin
      c = load_val; st = 2'b01;
    end else if (en) begin
      if (sum[4]) begin
        t = 1'b1; set = 1'b1;
        if (sat) begin c = 4'hF; st = 2'b10; end
        else begin c = sum[3:0]; st = 2'b01; end
      end else begin
        c = sum[3:0];
        if (st == 2'b00) st = 2'b01;
      end
    end
    if (set) o = 1'b1;
    else if (clr_ovf) o = 1'b0;
    return {st, o, t, c};
  endfunction

  task automatic tick(input string name);
    @(posedge clk);
    #1;
    $display("tx %-10s rst=%0b ld=%0b en=%0b stp=%0h | u0 c=%0h tc=%0b ov=%0b st=%0d | u1 c=%0h tc=%0b ov=%0b st=%0d",
             name, rst, load, en, step, count[0], tc[0], ovf[0], state[0],
             count[1], tc[1], ovf[1], state[1]);
  endtask

  initial begin
    logic [7:0] exp0, exp1;
    rst = 1'b1; en = 1'b1; load = 1'b0; clr_ovf = 1'b1; load_val = 4'h9; step = 4'h3;

    tick("reset");
    check("rst_u0", pk(0), 8'h00);
    check("rst_u1", pk(1), 8'h00);
    check("rst_add_a", {4'h0, add_a[0]}, 8'h00);
    check("rst_add_b", {4'h0, add_b[0]}, 8'h03);

    rst = 1'b0; clr_ovf = 1'b0; step = 4'h1;
    for (int i = 1; i <= 16; i++) begin
      tick("wrap16");
      check("wrap16_u0", pk(0), mk(2'b01, i == 16, i == 16, 4'(i)));
    end
    check("sat16_u1", pk(1), mk(2'b10, 1'b1, 1'b1, 4'hF));

    en = 1'b0;
    tick("hold");
    check("hold_u0", pk(0), mk(2'b01, 1'b1, 1'b0, 4'h0));
    check("hold_u1", pk(1), mk(2'b10, 1'b1, 1'b0, 4'hF));
    check("hold_add_b", {4'h0, add_b[0]}, 8'h00);

    load = 1'b1; load_val = 4'hF;
    tick("load_F");
    check("loadF_u0", pk(0), mk(2'b01, 1'b1, 1'b0, 4'hF));
    check("loadF_u1", pk(1), mk(2'b01, 1'b1, 1'b0, 4'hF));

    load = 1'b0; en = 1'b1; clr_ovf = 1'b1;
    tick("clr+wrap");
    check("setwins_u0", pk(0), mk(2'b01, 1'b1, 1'b1, 4'h0));
    check("setwins_u1", pk(1), mk(2'b10, 1'b1, 1'b1, 4'hF));

    en = 1'b0;
    tick("clr");
    check("clr_u0", pk(0), mk(2'b01, 1'b0, 1'b0, 4'h0));
    check("clr_u1", pk(1), mk(2'b10, 1'b0, 1'b0, 4'hF));

    clr_ovf = 1'b0; load = 1'b1; en = 1'b1; load_val = 4'h7; step = 4'h5;
    tick("load+en");
    check("ldpri_u0", pk(0), mk(2'b01, 1'b0, 1'b0, 4'h7));
    check("ldpri_u1", pk(1), mk(2'b01, 1'b0, 1'b0, 4'h7));

    en = 1'b0; load_val = 4'hD;
    tick("load_D");
    check("loadD_u1", pk(1), mk(2'b01, 1'b0, 1'b0, 4'hD));

    load = 1'b0; en = 1'b1; step = 4'h2;
    tick("D+2");
    check("D+2_u1", pk(1), mk(2'b01, 1'b0, 1'b0, 4'hF));
    check("D+2_u0", pk(0), mk(2'b01, 1'b0, 1'b0, 4'hF));
    check("sat_add_b", {4'h0, add_b[1]}, 8'h02);
    tick("F+2");
    check("F+2_u1", pk(1), mk(2'b10, 1'b1, 1'b1, 4'hF));
    check("F+2_u0", pk(0), mk(2'b01, 1'b1, 1'b1, 4'h1));
    tick("F+2b");
    check("F+2b_u1", pk(1), mk(2'b10, 1'b1, 1'b1, 4'hF));

    step = 4'h0;
    tick("satd_s0");
    check("satd_s0_u1", pk(1), mk(2'b10, 1'b1, 1'b0, 4'hF));
    check("s0_u0", pk(0), mk(2'b01, 1'b1, 1'b0, 4'h3));

    en = 1'b0; load = 1'b1; load_val = 4'h3;
    tick("load_3");
    check("unsat_u1", pk(1), mk(2'b01, 1'b1, 1'b0, 4'h3));

    load_val = 4'hA;
    tick("load_A");
    check("loadA_u0", pk(0), mk(2'b01, 1'b1, 1'b0, 4'hA));

    load = 1'b0; rst = 1'b1; en = 1'b1; step = 4'h9; clr_ovf = 1'b0;
    tick("rst_mid");
    check("rstmid_u0", pk(0), 8'h00);
    check("rstmid_u1", pk(1), 8'h00);
    check("rstmid_add_a", {4'h0, add_a[0]}, 8'h00);

    rst = 1'b0; step = 4'h5;
    tick("idle_en");
    check("idle_en_u0", pk(0), mk(2'b01, 1'b0, 1'b0, 4'h5));
    check("idle_en_u1", pk(1), mk(2'b01, 1'b0, 1'b0, 4'h5));

    rst = 1'b1;
    tick("rst_rand");
    check("rst_rand_u0", pk(0), 8'h00);
    exp0 = 8'h00; exp1 = 8'h00;
    for (int n = 0; n < 10000; n++) begin
      rst      = ($urandom_range(0, 99) == 0);
      en       = ($urandom_range(0, 3) != 0);
      load     = ($urandom_range(0, 15) == 0);
      clr_ovf  = ($urandom_range(0, 7) == 0);
      step     = 4'($urandom_range(0, 15));
      load_val = 4'($urandom_range(0, 15));
      exp0 = model_next(1'b0, exp0);
      exp1 = model_next(1'b1, exp1);
      @(posedge clk);
      #1;
      check("rand_u0", pk(0), exp0);
      check("rand_u1", pk(1), exp1);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
